// File: rtl/avalon_dram_mem_adapter_pkg.sv
// Shared DRAM definitions: controller command decode, adapter FSM states, Avalon burst constant.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package avalon_dram_mem_adapter_pkg;

  // Adapter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } adapter_state_e;

  // Avalon-MM side: single-beat transfers only
  localparam int                          AVL_BURSTCOUNT_W = 7;
  localparam logic [AVL_BURSTCOUNT_W-1:0] AVL_BURSTCOUNT   = 7'd1;

  // Controller-side request classification
  typedef enum logic [1:0] {
    CTRL_NONE     = 2'd0,
    CTRL_READ     = 2'd1,
    CTRL_WRITE    = 2'd2,
    CTRL_CONFLICT = 2'd3
  } ctrl_cmd_e;

  // Read wins over write when both strobes are present; the caller flags the conflict.
  function automatic ctrl_cmd_e decode_ctrl_cmd(input logic rd_en, input logic wr_en);
    if (rd_en && wr_en) return CTRL_CONFLICT;
    if (rd_en)          return CTRL_READ;
    if (wr_en)          return CTRL_WRITE;
    return CTRL_NONE;
  endfunction

endpackage

// File: rtl/avalon_dram_mem_adapter.sv
// DRAM controller to Avalon-MM single-beat adapter; optional read timeout via AVL_DRAM_ADAPTER_TIMEOUT_EN.
// Latency: accept at cycle 0, avl_read/avl_write from cycle 1, rd_data_val one cycle after avl_readdatavalid.
// Backpressure: rdy only in IDLE; avl_waitrequest stretches the command phase with all command fields held stable.
module avalon_dram_mem_adapter
  import avalon_dram_mem_adapter_pkg::*;
#(
  parameter int ADDR_W         = 26,
  parameter int DATA_W         = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  controller_mem_read_en,
  input  logic                  controller_mem_write_en,
  input  logic [ADDR_W-1:0]     controller_mem_addr,
  input  logic [DATA_W-1:0]     controller_mem_wr_data,
  input  logic [DATA_W/8-1:0]   controller_mem_byte_en,
  output logic                  mem_controller_rdy,
  output logic                  mem_controller_rd_data_val,
  output logic [DATA_W-1:0]     mem_controller_rd_data,
  output logic [ADDR_W-1:0]     avl_address,
  output logic                  avl_read,
  output logic                  avl_write,
  output logic [DATA_W-1:0]     avl_writedata,
  output logic [DATA_W/8-1:0]   avl_byteenable,
  output logic [6:0]            avl_burstcount,
  input  logic                  avl_waitrequest,
  input  logic [DATA_W-1:0]     avl_readdata,
  input  logic                  avl_readdatavalid,
  output logic                  adapter_err
);

  localparam int BE_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  adapter_state_e    state_q,       state_d;
  logic [ADDR_W-1:0] addr_q,        addr_d;
  logic [DATA_W-1:0] wr_data_q,     wr_data_d;
  logic [BE_W-1:0]   byte_en_q,     byte_en_d;
  logic [DATA_W-1:0] rd_data_q,     rd_data_d;
  logic              rd_data_val_q, rd_data_val_d;
  logic              avl_read_q,    avl_read_d;
  logic              avl_write_q,   avl_write_d;
  logic              adapter_err_q, adapter_err_d;
  ctrl_cmd_e         cmd;

`ifdef AVL_DRAM_ADAPTER_TIMEOUT_EN
  localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter holds (RD_WAIT cycles elapsed - 1); the last permitted cycle is TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state and datapath capture for the request/response FSM
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    byte_en_d     = byte_en_q;
    rd_data_d     = rd_data_q;
    rd_data_val_d = 1'b0;
    avl_read_d    = avl_read_q;
    avl_write_d   = avl_write_q;
    adapter_err_d = adapter_err_q;
    cmd           = decode_ctrl_cmd(controller_mem_read_en, controller_mem_write_en);
`ifdef AVL_DRAM_ADAPTER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd == CTRL_READ || cmd == CTRL_CONFLICT) begin
          addr_d     = controller_mem_addr;
          avl_read_d = 1'b1;
          state_d    = RD_REQ;
          if (cmd == CTRL_CONFLICT) adapter_err_d = 1'b1;
        end else if (cmd == CTRL_WRITE) begin
          addr_d      = controller_mem_addr;
          wr_data_d   = controller_mem_wr_data;
          byte_en_d   = controller_mem_byte_en;
          avl_write_d = 1'b1;
          state_d     = WR_REQ;
        end
      end
      RD_REQ: begin
        if (!avl_waitrequest) begin
          avl_read_d = 1'b0;
          state_d    = RD_WAIT;
`ifdef AVL_DRAM_ADAPTER_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      RD_WAIT: begin
        if (avl_readdatavalid) begin
          rd_data_d     = avl_readdata;
          rd_data_val_d = 1'b1;
          state_d       = IDLE;
        end
`ifdef AVL_DRAM_ADAPTER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          // Give the controller a zero beat so it never stalls on a lost read.
          rd_data_d     = '0;
          rd_data_val_d = 1'b1;
          adapter_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      WR_REQ: begin
        if (!avl_waitrequest) begin
          avl_write_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data with no outstanding read is dropped and flagged.
    if (avl_readdatavalid && state_q != RD_WAIT) adapter_err_d = 1'b1;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wr_data_q     <= '0;
      byte_en_q     <= '0;
      rd_data_q     <= '0;
      rd_data_val_q <= 1'b0;
      avl_read_q    <= 1'b0;
      avl_write_q   <= 1'b0;
      adapter_err_q <= 1'b0;
`ifdef AVL_DRAM_ADAPTER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      byte_en_q     <= byte_en_d;
      rd_data_q     <= rd_data_d;
      rd_data_val_q <= rd_data_val_d;
      avl_read_q    <= avl_read_d;
      avl_write_q   <= avl_write_d;
      adapter_err_q <= adapter_err_d;
`ifdef AVL_DRAM_ADAPTER_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign mem_controller_rdy         = (state_q == IDLE);
  assign mem_controller_rd_data_val = rd_data_val_q;
  assign mem_controller_rd_data     = rd_data_q;
  assign avl_address                = addr_q;
  assign avl_read                   = avl_read_q;
  assign avl_write                  = avl_write_q;
  assign avl_writedata              = wr_data_q;
  assign avl_byteenable             = byte_en_q;
  assign avl_burstcount             = AVL_BURSTCOUNT;
  assign adapter_err                = adapter_err_q;

endmodule

// File: tb/tb_avalon_dram_mem_adapter.sv
// Bench for avalon_dram_mem_adapter: directed scenarios plus randomized transactions with busy-time strobe noise.
// Latency: expected cycle numbers come from the transaction-level rules (accept=0, command from 1, return +1).
// Backpressure: the bench acts as the Avalon slave, holding waitrequest high for a chosen number of command cycles.
module tb_avalon_dram_mem_adapter;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 512;
  localparam int BE_W   = DATA_W / 8;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              read_en, write_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   byte_en;
  logic              mem_controller_rdy, rd_data_val;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] avl_address;
  logic              avl_read, avl_write;
  logic [DATA_W-1:0] avl_writedata;
  logic [BE_W-1:0]   avl_byteenable;
  logic [6:0]        avl_burstcount;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              adapter_err;

  int checks   = 0;
  int failures = 0;

  avalon_dram_mem_adapter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .controller_mem_read_en     (read_en),
    .controller_mem_write_en    (write_en),
    .controller_mem_addr        (addr),
    .controller_mem_wr_data     (wr_data),
    .controller_mem_byte_en     (byte_en),
    .mem_controller_rdy         (mem_controller_rdy),
    .mem_controller_rd_data_val (rd_data_val),
    .mem_controller_rd_data     (rd_data),
    .avl_address                (avl_address),
    .avl_read                   (avl_read),
    .avl_write                  (avl_write),
    .avl_writedata              (avl_writedata),
    .avl_byteenable             (avl_byteenable),
    .avl_burstcount             (avl_burstcount),
    .avl_waitrequest            (waitrequest),
    .avl_readdata               (readdata),
    .avl_readdatavalid          (readdatavalid),
    .adapter_err                (adapter_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BE_W-1:0] rand_be();
    logic [BE_W-1:0] v;
    for (int i = 0; i < BE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; read_en = 1'b0; write_en = 1'b0; readdatavalid = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One controller request (cycle 0) followed by 'budget' observed cycles acting as the Avalon slave.
  // waitrequest stays high for the first wait_n command cycles; readdatavalid fires in cycle rdv_at.
  task automatic run_txn(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be,
                         input int wait_n, input int rdv_at, input logic [DATA_W-1:0] rdata,
                         input int budget, input logic noise,
                         output int n_rd, output int n_wr, output int val_cyc, output int val_cnt,
                         output logic [DATA_W-1:0] got, output logic [DATA_W-1:0] fin_data,
                         output int bad_cmd, output int rdy_cyc);
    n_rd = 0; n_wr = 0; val_cyc = -1; val_cnt = 0; got = '0; bad_cmd = 0; rdy_cyc = -1;
    @(negedge clk);
    read_en = rd; write_en = wr; addr = a; wr_data = wd; byte_en = be;
    waitrequest = 1'b1; readdatavalid = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (avl_read) begin
        n_rd++;
        if (avl_address !== a) bad_cmd++;
      end
      if (avl_write) begin
        n_wr++;
        if (avl_address !== a || avl_writedata !== wd || avl_byteenable !== be) bad_cmd++;
      end
      if (avl_read && avl_write) bad_cmd++;
      if (avl_burstcount !== 7'd1) bad_cmd++;
      if (rd_data_val) begin
        val_cnt++;
        if (val_cyc < 0) begin
          val_cyc = c;
          got     = rd_data;
        end
      end
      if (mem_controller_rdy && rdy_cyc < 0) rdy_cyc = c;
      if (noise && !mem_controller_rdy) begin
        read_en  = 1'($urandom);
        write_en = 1'($urandom);
        addr     = ADDR_W'($urandom);
        wr_data  = rand_data();
        byte_en  = rand_be();
      end else begin
        read_en  = 1'b0;
        write_en = 1'b0;
      end
      waitrequest   = ((n_rd + n_wr) <= wait_n);
      readdatavalid = (c == rdv_at);
      readdata      = (c == rdv_at) ? rdata : rand_data();
    end
    fin_data = rd_data;
    read_en = 1'b0; write_en = 1'b0; readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_controller_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", mem_controller_rdy); end
    checks++; if (avl_read !== 1'b0 || avl_write !== 1'b0) begin failures++; $display("FAIL reset_cmd rd=%b wr=%b exp=0/0", avl_read, avl_write); end
    checks++; if (rd_data_val !== 1'b0 || adapter_err !== 1'b0) begin failures++; $display("FAIL reset_flags val=%b err=%b exp=0/0", rd_data_val, adapter_err); end
    checks++; if (rd_data !== '0 || avl_address !== '0 || avl_writedata !== '0 || avl_byteenable !== '0) begin
      failures++; $display("FAIL reset_regs addr=%h rd_data_lo=%h exp=0", avl_address, rd_data[31:0]); end
    checks++; if (avl_burstcount !== 7'd1) begin failures++; $display("FAIL reset_burst got=%0d exp=1", avl_burstcount); end
  endtask

  task automatic test_read_waitstate();
    int nr, nw, vc, vn, bc, rc;
    logic [DATA_W-1:0] g, f, pat;
    pat = {64{8'hA5}};
    do_reset();
    run_txn(1'b1, 1'b0, 26'h10, '0, '0, 3, 5, pat, 10, 1'b0, nr, nw, vc, vn, g, f, bc, rc);
    checks++; if (nr !== 4) begin failures++; $display("FAIL rd_ws_avl_read_cycles got=%0d exp=4", nr); end
    checks++; if (vc !== 6 || vn !== 1) begin failures++; $display("FAIL rd_ws_val got_cyc=%0d cnt=%0d exp=6/1", vc, vn); end
    checks++; if (g !== pat || f !== pat) begin failures++; $display("FAIL rd_ws_data got=%h exp=%h", g[31:0], pat[31:0]); end
    checks++; if (bc !== 0 || nw !== 0) begin failures++; $display("FAIL rd_ws_cmd bad=%0d writes=%0d exp=0/0", bc, nw); end
    checks++; if (rc !== 6 || adapter_err !== 1'b0) begin failures++; $display("FAIL rd_ws_rdy got_cyc=%0d err=%b exp=6/0", rc, adapter_err); end
  endtask

  task automatic test_write();
    int nr, nw, vc, vn, bc, rc;
    logic [DATA_W-1:0] g, f;
    run_txn(1'b0, 1'b1, 26'h20, DATA_W'(16'h1234), '1, 0, -1, '0, 5, 1'b0, nr, nw, vc, vn, g, f, bc, rc);
    checks++; if (nw !== 1 || nr !== 0) begin failures++; $display("FAIL wr_cycles got_wr=%0d got_rd=%0d exp=1/0", nw, nr); end
    checks++; if (bc !== 0) begin failures++; $display("FAIL wr_fields bad=%0d exp=0", bc); end
    checks++; if (rc !== 2 || vn !== 0) begin failures++; $display("FAIL wr_rdy got_cyc=%0d vals=%0d exp=2/0", rc, vn); end
  endtask

  task automatic test_simultaneous();
    int nr, nw, vc, vn, bc, rc;
    logic [DATA_W-1:0] g, f, d;
    d = rand_data();
    do_reset();
    run_txn(1'b1, 1'b1, 26'h3, rand_data(), rand_be(), 0, 3, d, 8, 1'b0, nr, nw, vc, vn, g, f, bc, rc);
    checks++; if (nw !== 0 || nr !== 1) begin failures++; $display("FAIL simul_cmd got_wr=%0d got_rd=%0d exp=0/1", nw, nr); end
    checks++; if (adapter_err !== 1'b1) begin failures++; $display("FAIL simul_err got=%b exp=1", adapter_err); end
    checks++; if (g !== d || vc !== 4) begin failures++; $display("FAIL simul_rdata cyc=%0d got=%h exp=4/%h", vc, g[31:0], d[31:0]); end
  endtask

  task automatic test_spurious();
    int vals;
    do_reset();
    @(negedge clk);
    readdatavalid = 1'b1; readdata = rand_data();
    vals = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      readdatavalid = 1'b0;
      if (rd_data_val) vals++;
    end
    checks++; if (vals !== 0) begin failures++; $display("FAIL spurious_val got=%0d exp=0", vals); end
    checks++; if (adapter_err !== 1'b1 || mem_controller_rdy !== 1'b1) begin failures++; $display("FAIL spurious_err err=%b rdy=%b exp=1/1", adapter_err, mem_controller_rdy); end
  endtask

  task automatic test_reset_mid();
    int vals;
    // adapter_err is already set by the spurious test, so the reset must clear it.
    @(negedge clk);
    read_en = 1'b1; addr = 26'h155; waitrequest = 1'b0;
    @(negedge clk);
    read_en = 1'b0;
    checks++; if (avl_read !== 1'b1) begin failures++; $display("FAIL rstmid_read got=%b exp=1", avl_read); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mem_controller_rdy !== 1'b1 || avl_read !== 1'b0 || avl_write !== 1'b0) begin
      failures++; $display("FAIL rstmid_after rdy=%b rd=%b wr=%b exp=1/0/0", mem_controller_rdy, avl_read, avl_write); end
    checks++; if (adapter_err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", adapter_err); end
    readdatavalid = 1'b1; readdata = rand_data();
    vals = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      readdatavalid = 1'b0;
      if (rd_data_val) vals++;
    end
    checks++; if (vals !== 0 || rd_data !== '0) begin failures++; $display("FAIL rstmid_val vals=%0d data_lo=%h exp=0/0", vals, rd_data[31:0]); end
  endtask

  task automatic test_random();
    int nr, nw, vc, vn, bc, rc, wn, ra;
    logic is_rd;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] g, f, d, wd;
    logic [BE_W-1:0] be;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      is_rd = 1'($urandom);
      a     = ADDR_W'($urandom);
      wd    = rand_data();
      be    = rand_be();
      d     = rand_data();
      wn    = int'($urandom_range(0, 4));
      ra    = is_rd ? wn + 2 + int'($urandom_range(0, 3)) : -1;
      run_txn(is_rd, !is_rd, a, wd, be, wn, ra, d, wn + 9, 1'b1, nr, nw, vc, vn, g, f, bc, rc);
      checks++; if (bc !== 0) begin failures++; $display("FAIL rand_cmd it=%0d bad=%0d exp=0", it, bc); end
      if (is_rd) begin
        checks++; if (nr !== wn + 1 || nw !== 0) begin failures++; $display("FAIL rand_rd_cycles it=%0d got=%0d/%0d exp=%0d/0", it, nr, nw, wn + 1); end
        checks++; if (vc !== ra + 1 || vn !== 1 || rc !== ra + 1) begin
          failures++; $display("FAIL rand_rd_timing it=%0d val=%0d cnt=%0d rdy=%0d exp=%0d/1/%0d", it, vc, vn, rc, ra + 1, ra + 1); end
        checks++; if (g !== d || f !== d) begin failures++; $display("FAIL rand_rd_data it=%0d got=%h exp=%h", it, g[31:0], d[31:0]); end
      end else begin
        checks++; if (nw !== wn + 1 || nr !== 0) begin failures++; $display("FAIL rand_wr_cycles it=%0d got=%0d/%0d exp=%0d/0", it, nw, nr, wn + 1); end
        checks++; if (rc !== wn + 2 || vn !== 0) begin failures++; $display("FAIL rand_wr_rdy it=%0d rdy=%0d vals=%0d exp=%0d/0", it, rc, vn, wn + 2); end
      end
      checks++; if (adapter_err !== 1'b0) begin failures++; $display("FAIL rand_err it=%0d got=%b exp=0", it, adapter_err); end
    end
  endtask

  task automatic test_timeout();
    int nr, nw, vc, vn, bc, rc;
    logic [DATA_W-1:0] g, f, d;
    d = rand_data();
    do_reset();
    run_txn(1'b1, 1'b0, 26'h44, '0, '0, 0, 3, d, 6, 1'b0, nr, nw, vc, vn, g, f, bc, rc);
    checks++; if (g !== d) begin failures++; $display("FAIL tmo_prime got=%h exp=%h", g[31:0], d[31:0]); end
`ifdef AVL_DRAM_ADAPTER_TIMEOUT_EN
    // handshake in cycle 2, then TMO RD_WAIT cycles, zero beat one cycle later
    run_txn(1'b1, 1'b0, 26'h48, '0, '0, 1, -1, '0, TMO + 8, 1'b0, nr, nw, vc, vn, g, f, bc, rc);
    checks++; if (vc !== TMO + 3 || vn !== 1) begin failures++; $display("FAIL tmo_val cyc=%0d cnt=%0d exp=%0d/1", vc, vn, TMO + 3); end
    checks++; if (g !== '0) begin failures++; $display("FAIL tmo_data got=%h exp=0", g[31:0]); end
    checks++; if (adapter_err !== 1'b1 || rc !== TMO + 3) begin failures++; $display("FAIL tmo_err err=%b rdy=%0d exp=1/%0d", adapter_err, rc, TMO + 3); end
`else
    // without the timeout the adapter waits well past TMO cycles for the data
    d = rand_data();
    run_txn(1'b1, 1'b0, 26'h48, '0, '0, 0, 42, d, 46, 1'b0, nr, nw, vc, vn, g, f, bc, rc);
    checks++; if (vc !== 43 || vn !== 1) begin failures++; $display("FAIL notmo_val cyc=%0d cnt=%0d exp=43/1", vc, vn); end
    checks++; if (g !== d || adapter_err !== 1'b0) begin failures++; $display("FAIL notmo_data got=%h err=%b exp=%h/0", g[31:0], adapter_err, d[31:0]); end
`endif
  endtask

  initial begin
    rst = 1'b1; read_en = 1'b0; write_en = 1'b0; addr = '0; wr_data = '0; byte_en = '0;
    waitrequest = 1'b0; readdata = '0; readdatavalid = 1'b0;
    test_reset();
    test_read_waitstate();
    test_write();
    test_simultaneous();
    test_spurious();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
